// File: rtl/wbi_pkg.sv
// Shared types and constants for the WBI master port: FSM states, TID layout
// and the response timeout limit.
package wbi_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        RESP = 2'd2
    } wbi_state_e;

    // TID = {master id, sequence number}
    localparam int unsigned TID_W   = 4;
    localparam int unsigned MID_W   = 2;
    localparam int unsigned SEQ_W   = 2;
    localparam int unsigned SEQ_LSB = 0;
    localparam int unsigned MID_LSB = SEQ_LSB + SEQ_W;

    // Response timeout counter
    localparam int unsigned         TMO_W     = 12;
    localparam logic [TMO_W-1:0]    TMO_LIMIT = 12'hFFF;

    // Build a transaction tag from master id and sequence number
    function automatic logic [TID_W-1:0] make_tid(input logic [MID_W-1:0] mid,
                                                  input logic [SEQ_W-1:0] seq);
        return {mid, seq};
    endfunction

endpackage

// File: rtl/wbi_mp_timer.sv
// Response timeout counter for wbi_master_port. Counts cycles spent waiting
// for a response, clears on every matching beat, flags expiry at the limit.
module wbi_mp_timer
    import wbi_pkg::*;
(
    input  logic mclk,
    input  logic reset,
    input  logic run,
    input  logic clr,
    output logic expired
);

    logic [TMO_W-1:0] cnt;

    // Free-running while waiting; held at zero otherwise
    always_ff @(posedge mclk) begin
        if (reset || !run || clr) begin
            cnt <= '0;
        end else if (cnt != TMO_LIMIT) begin
            cnt <= cnt + TMO_W'(1);
        end
    end

    // A matching beat in the same cycle wins over expiry
    assign expired = run && !clr && (cnt == TMO_LIMIT);

endmodule

// File: rtl/wbi_master_port.sv
// WBI master port: Wishbone master (cyc/stb, bl/bry bursts) to WBI command
// stream, and WBI response stream back to Wishbone ack/lack/err.
// Optional feature: define WBI_MP_TIMEOUT_EN to enable the response timeout.
module wbi_master_port
    import wbi_pkg::*;
#(
    parameter int unsigned      AW  = 32,
    parameter int unsigned      DW  = 32,
    parameter int unsigned      BW  = 4,
    parameter int unsigned      BL  = 10,
    parameter logic [MID_W-1:0] MID = 2'b00
) (
    input  logic             mclk,
    input  logic             reset,
    // Wishbone master side
    input  logic             wbm_cyc_i,
    input  logic             wbm_stb_i,
    input  logic [AW-1:0]    wbm_adr_i,
    input  logic             wbm_we_i,
    input  logic [BW-1:0]    wbm_sel_i,
    input  logic [DW-1:0]    wbm_dat_i,
    input  logic [BL-1:0]    wbm_bl_i,
    input  logic             wbm_bry_i,
    output logic             wbm_wnext_o,
    output logic [DW-1:0]    wbm_dat_o,
    output logic             wbm_ack_o,
    output logic             wbm_lack_o,
    output logic             wbm_err_o,
    // Command stream to the chain
    input  logic             wbp_cmd_wrdy_i,
    output logic             wbp_cmd_wval_o,
    output logic [AW-1:0]    wbp_cmd_adr_o,
    output logic             wbp_cmd_we_o,
    output logic [DW-1:0]    wbp_cmd_dat_o,
    output logic [BW-1:0]    wbp_cmd_sel_o,
    output logic [TID_W-1:0] wbp_cmd_tid_o,
    output logic [BL-1:0]    wbp_cmd_bl_o,
    // Response stream from the chain
    output logic             wbp_res_rrdy_o,
    input  logic             wbp_res_rval_i,
    input  logic [DW-1:0]    wbp_res_dat_i,
    input  logic             wbp_res_ack_i,
    input  logic             wbp_res_lack_i,
    input  logic             wbp_res_err_i,
    input  logic [TID_W-1:0] wbp_res_tid_i
);

    wbi_state_e       state;
    logic [SEQ_W-1:0] seq;
    logic [BL-1:0]    beat_cnt;
    logic             abandon;

    logic             in_cmd;
    logic             in_resp;
    logic             drop;
    logic             cmd_fire;
    logic [BL-1:0]    beat_total;
    logic             last_beat;
    logic             res_match;
    logic             res_done;
    logic             tmo_hit;
    logic             beat_vis;
    logic             tmo_vis;

    assign in_cmd  = (state == CMD);
    assign in_resp = (state == RESP);

    // Master has gone away: finish the transaction silently
    assign drop = abandon | ~wbm_cyc_i;

    // Command handshake; an abandoned write no longer waits for bry
    assign wbp_cmd_wval_o = in_cmd & (~wbp_cmd_we_o | wbm_bry_i | drop);
    assign cmd_fire       = wbp_cmd_wval_o & wbp_cmd_wrdy_i;
    assign wbp_cmd_dat_o  = in_cmd ? wbm_dat_i : '0;
    assign wbm_wnext_o    = cmd_fire & wbp_cmd_we_o & ~drop;

    // Burst length zero means a single beat
    assign beat_total = (wbp_cmd_bl_o == '0) ? BL'(1) : wbp_cmd_bl_o;
    assign last_beat  = ~wbp_cmd_we_o | (beat_cnt == beat_total - BL'(1));

    // Only tagged, acknowledged beats for the current transaction count
    assign res_match = in_resp & wbp_res_rval_i & wbp_res_rrdy_o & wbp_res_ack_i
                     & (wbp_res_tid_i == wbp_cmd_tid_o);
    assign res_done  = res_match & wbp_res_lack_i;

`ifdef WBI_MP_TIMEOUT_EN
    wbi_mp_timer u_timer (
        .mclk    (mclk),
        .reset   (reset),
        .run     (in_resp),
        .clr     (res_match),
        .expired (tmo_hit)
    );
`else
    assign tmo_hit = 1'b0;
`endif

    // Wishbone response, suppressed once the master dropped cyc
    assign beat_vis   = res_match & ~drop;
    assign tmo_vis    = tmo_hit & ~drop;
    assign wbm_ack_o  = beat_vis | tmo_vis;
    assign wbm_lack_o = (beat_vis & wbp_res_lack_i) | tmo_vis;
    assign wbm_err_o  = (beat_vis & wbp_res_err_i) | tmo_vis;
    assign wbm_dat_o  = beat_vis ? wbp_res_dat_i : '0;

    // Transaction FSM with registered command fields
    always_ff @(posedge mclk) begin
        if (reset) begin
            state          <= IDLE;
            seq            <= '0;
            beat_cnt       <= '0;
            abandon        <= 1'b0;
            wbp_res_rrdy_o <= 1'b0;
            wbp_cmd_adr_o  <= '0;
            wbp_cmd_we_o   <= 1'b0;
            wbp_cmd_sel_o  <= '0;
            wbp_cmd_tid_o  <= '0;
            wbp_cmd_bl_o   <= '0;
        end else begin
            wbp_res_rrdy_o <= 1'b1;
            case (state)
                IDLE: begin
                    abandon <= 1'b0;
                    if (wbm_cyc_i && wbm_stb_i) begin
                        wbp_cmd_adr_o <= wbm_adr_i;
                        wbp_cmd_we_o  <= wbm_we_i;
                        wbp_cmd_sel_o <= wbm_sel_i;
                        wbp_cmd_bl_o  <= wbm_bl_i;
                        wbp_cmd_tid_o <= make_tid(MID, seq);
                        beat_cnt      <= '0;
                        state         <= CMD;
                    end
                end
                CMD: begin
                    if (!wbm_cyc_i) begin
                        abandon <= 1'b1;
                    end
                    if (cmd_fire) begin
                        if (last_beat) begin
                            state <= RESP;
                        end else begin
                            beat_cnt <= beat_cnt + BL'(1);
                        end
                    end
                end
                RESP: begin
                    if (!wbm_cyc_i) begin
                        abandon <= 1'b1;
                    end
                    if (res_done || tmo_hit) begin
                        seq   <= seq + SEQ_W'(1);
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
